iq_packetizer: RTL

//  Buffers the continuous 32-bit IQ sample stream from the DSP chain in a FIFO.

---
 rtl/iq_packetizer_if.sv | 31 +++
 rtl/iq_packetizer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/iq_packetizer_if.sv
// iq_packetizer_if: bundles the sample-input stream, the flush strobe and the
// UDP application-side payload stream of iq_packetizer.
//   iq_data/iq_valid/iq_ready : 32-bit IQ sample stream into the packetizer
//   flush                     : 1-cycle request to emit whatever is buffered
//   app_data/app_len/app_valid/app_last/app_ready : payload burst stream out
// Modports:
//   master : the packetizer (sources the app stream, sinks the sample stream)
//   slave  : the surrounding logic (DSP chain + UDP/IP stack side)
interface iq_packetizer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] iq_data;
  logic                  iq_valid;
  logic                  iq_ready;
  logic                  flush;
  logic [DATA_WIDTH-1:0] app_data;
  logic [15:0]           app_len;
  logic                  app_valid;
  logic                  app_last;
  logic                  app_ready;

  modport master (
    input  iq_data, iq_valid, flush, app_ready,
    output iq_ready, app_data, app_len, app_valid, app_last
  );

  modport slave (
    output iq_data, iq_valid, flush, app_ready,
    input  iq_ready, app_data, app_len, app_valid, app_last
  );
endinterface

// File: rtl/iq_packetizer.sv
// iq_packetizer: buffers the 32-bit IQ sample stream in a FIFO and emits it as
// UDP payload bursts of up to PKT_WORDS words, each carrying its byte length.
// Partial bursts go out on idle timeout or on an explicit flush.
// Ports:
//   clk, rst      : 125 MHz clock, synchronous active-high reset
//   bus (master)  : iq_data/iq_valid/iq_ready sample input, flush strobe,
//                   app_data/app_len/app_valid/app_last/app_ready burst output
//   overflow_cnt  : samples dropped while the FIFO was full (saturating)
//   pkt_cnt       : completed bursts (wrapping)
// Build option: define SEQ_HDR_EN to prefix every burst with a 32-bit
// sequence-number header word (0 after reset, +1 per completed burst).
module iq_packetizer #(
  parameter int DATA_WIDTH     = 32,
  parameter int PKT_WORDS      = 256,
  parameter int FIFO_DEPTH     = 1024,
  parameter int TIMEOUT_CYCLES = 12500
) (
  input  logic            clk,
  input  logic            rst,
  iq_packetizer_if.master bus,
  output logic [15:0]     overflow_cnt,
  output logic [31:0]     pkt_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] PKT_C    = CW'(PKT_WORDS);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
`ifdef SEQ_HDR_EN
  localparam logic [CW-1:0] HDR_BEATS = CW'(1);
`else
  localparam logic [CW-1:0] HDR_BEATS = '0;
`endif

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           diff;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] head;

  logic [0:0]            state;
  logic [TW-1:0]         idle_tmr;
  logic                  flush_pend;
  logic                  flush_req;
  logic                  rule_a;
  logic                  rule_b;
  logic                  rule_c;
  logic                  launch;
  logic [CW-1:0]         burst;
  logic [CW-1:0]         beats_new;
  logic [CW-1:0]         beats_left;
  logic                  beat;
`ifdef SEQ_HDR_EN
  logic [DATA_WIDTH-1:0] seq_num;
  logic                  hdr_phase;
`endif

  // FIFO occupancy: pointers carry one extra wrap bit so full and empty differ
  assign diff  = wr_ptr - rd_ptr;
  assign count = {1'b0, diff};
  assign full  = (count == DEPTH_C);
  assign wr_en = bus.iq_valid && !full;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign bus.iq_ready = !full;
  assign beat         = bus.app_valid && bus.app_ready;
  assign bus.app_last = bus.app_valid && (beats_left == ONE_C);

`ifdef SEQ_HDR_EN
  assign bus.app_data = !bus.app_valid ? '0 : (hdr_phase ? seq_num : head);
  assign rd_en        = beat && !hdr_phase;
`else
  assign bus.app_data = bus.app_valid ? head : '0;
  assign rd_en        = beat;
`endif

  // Launch rules. When (a) does not hold, count < PKT_WORDS, so both the
  // flush and timeout bursts reduce to the current occupancy.
  assign flush_req = bus.flush || flush_pend;
  assign rule_a    = (count >= PKT_C);
  assign rule_c    = flush_req && (count != '0);
  assign rule_b    = (count != '0) && (idle_tmr == TMR_LAST);
  assign launch    = (state == IDLE) && (rule_a || rule_c || rule_b);
  assign burst     = rule_a ? PKT_C : count;
  assign beats_new = burst + HDR_BEATS;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= bus.iq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      state         <= IDLE;
      idle_tmr      <= '0;
      flush_pend    <= 1'b0;
      beats_left    <= '0;
      bus.app_valid <= 1'b0;
      bus.app_len   <= '0;
      overflow_cnt  <= '0;
      pkt_cnt       <= '0;
`ifdef SEQ_HDR_EN
      seq_num       <= '0;
      hdr_phase     <= 1'b0;
`endif
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (bus.iq_valid && full && (overflow_cnt != '1)) begin
        overflow_cnt <= overflow_cnt + 1'b1;
      end

      // A fresh sample restarts the idle count, so only a quiet input times out
      if ((state != IDLE) || (count == '0) || launch || wr_en) begin
        idle_tmr <= '0;
      end else begin
        idle_tmr <= idle_tmr + 1'b1;
      end

      // A flush pre-empted by a full burst stays pending for the next IDLE pass
      if (state == IDLE) begin
        if (count == '0) begin
          flush_pend <= 1'b0;
        end else if (rule_a) begin
          flush_pend <= flush_req;
        end else if (launch) begin
          flush_pend <= 1'b0;
        end
      end else if (bus.flush) begin
        flush_pend <= (count != '0);
      end

      if (state == IDLE) begin
        if (launch) begin
          state       <= SEND;
          beats_left  <= beats_new;
          bus.app_len <= 16'({beats_new, 2'b00});
`ifdef SEQ_HDR_EN
          hdr_phase   <= 1'b1;
`endif
        end
      end else begin
        // First SEND cycle raises app_valid; it then stays up until the last beat
        if (!bus.app_valid) begin
          bus.app_valid <= 1'b1;
        end else if (beat) begin
          beats_left <= beats_left - 1'b1;
`ifdef SEQ_HDR_EN
          hdr_phase  <= 1'b0;
`endif
          if (beats_left == ONE_C) begin
            bus.app_valid <= 1'b0;
            state         <= IDLE;
            pkt_cnt       <= pkt_cnt + 1'b1;
`ifdef SEQ_HDR_EN
            seq_num       <= seq_num + 1'b1;
`endif
          end
        end
      end
    end
  end
endmodule
